// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter: FSM state enum,
// width derivation helpers and the byte-merge used by read-modify-write.
package ram_arb_pkg;

  typedef enum logic {IDLE, RMW} arb_state_e;

  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  // Operates on the widest supported word; callers zero-extend and truncate.
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] new_word,
                                                    input logic [MAX_DW-1:0] old_word,
                                                    input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_BE; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker. Search starts at the pointer and wraps; the pointer
// moves to one past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] ptr;
  int            cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (i_en && !o_valid && i_req[cand]) begin
        o_valid     = 1'b1;
        o_idx       = IW'(cand);
        o_gnt[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (o_valid) begin
      ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one word-only RAM port between N_REQ requesters with round-robin
// fairness, adding byte-enable writes through a two-cycle read-modify-write.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DEPTH      = 2**16,
  parameter int DATA_WIDTH = 32,
  localparam int AW   = addr_width(DEPTH),
  localparam int BE_W = be_width(DATA_WIDTH),
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [N_REQ-1:0]                 i_req,
  input  logic [N_REQ-1:0]                 i_we,
  input  logic [N_REQ-1:0][AW-1:0]         i_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] i_wdata,
  input  logic [N_REQ-1:0][BE_W-1:0]       i_be,
  output logic [N_REQ-1:0]                 o_gnt,
  output logic [N_REQ-1:0]                 o_rvalid,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic [AW-1:0]                    o_ram_addr,
  output logic [DATA_WIDTH-1:0]            o_ram_data,
  output logic                             o_ram_we,
  input  logic [DATA_WIDTH-1:0]            i_ram_data
);

  arb_state_e state, next_state;

  logic                  arb_en;
  logic                  arb_valid;
  logic [IW-1:0]         arb_idx;
  logic [N_REQ-1:0]      arb_gnt;
  logic [N_REQ-1:0]      read_issue;
  logic                  rmw_load;
  logic [BE_W-1:0]       cur_be;
  logic [AW-1:0]         rmw_addr;
  logic [DATA_WIDTH-1:0] rmw_wdata;
  logic [BE_W-1:0]       rmw_be;
  logic [DATA_WIDTH-1:0] rdata_hold;
  logic [MAX_DW-1:0]     merged_wide;

  // Gating with i_rst_n keeps every command output quiet while reset is held.
  assign arb_en = i_rst_n && (state == IDLE);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .i_en    (arb_en),
    .o_gnt   (arb_gnt),
    .o_idx   (arb_idx),
    .o_valid (arb_valid)
  );

  assign o_gnt       = arb_gnt;
  assign merged_wide = merge_bytes(MAX_DW'(rmw_wdata), MAX_DW'(i_ram_data), MAX_BE'(rmw_be));
  assign o_rdata     = (|o_rvalid) ? i_ram_data : rdata_hold;

  always_comb begin
    next_state = state;
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    rmw_load   = 1'b0;
    read_issue = '0;
    cur_be     = i_be[arb_idx];
    case (state)
      IDLE: begin
        if (arb_valid) begin
          if (!i_we[arb_idx]) begin
            o_ram_addr = i_addr[arb_idx];
            read_issue = arb_gnt;
          end else if (cur_be == {BE_W{1'b1}}) begin
            o_ram_we   = 1'b1;
            o_ram_addr = i_addr[arb_idx];
            o_ram_data = i_wdata[arb_idx];
          end else if (cur_be != '0) begin
            // Partial write: fetch the old word now, merge and write next cycle.
            o_ram_addr = i_addr[arb_idx];
            rmw_load   = 1'b1;
            next_state = RMW;
          end
        end
      end
      RMW: begin
        o_ram_we   = 1'b1;
        o_ram_addr = rmw_addr;
        o_ram_data = merged_wide[DATA_WIDTH-1:0];
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_rvalid   <= '0;
      rdata_hold <= '0;
      rmw_addr   <= '0;
      rmw_wdata  <= '0;
      rmw_be     <= '0;
    end else begin
      state    <= next_state;
      o_rvalid <= read_issue;
      if (|o_rvalid) rdata_hold <= i_ram_data;
      if (rmw_load) begin
        rmw_addr  <= i_addr[arb_idx];
        rmw_wdata <= i_wdata[arb_idx];
        rmw_be    <= cur_be;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter driving a small write-first RAM model on port A.
module tb_ram_port_arbiter;

  localparam int N   = 2;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int BW  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N-1:0]         we = '0;
  logic [N-1:0][AW-1:0] addr = '0;
  logic [N-1:0][DW-1:0] wdata = '0;
  logic [N-1:0][BW-1:0] be = '0;
  logic [N-1:0]         gnt;
  logic [N-1:0]         rvalid;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_wd;
  logic                 ram_we;
  logic [DW-1:0]        ram_q = '0;
  logic [DW-1:0]        mem [DEP];

  int n_checks = 0;
  int n_fail   = 0;
  int g0, g1;

  always #5 clk = ~clk;

  ram_port_arbiter #(.N_REQ(N), .DEPTH(DEP), .DATA_WIDTH(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_be       (be),
    .o_gnt      (gnt),
    .o_rvalid   (rvalid),
    .o_rdata    (rdata),
    .o_ram_addr (ram_addr),
    .o_ram_data (ram_wd),
    .o_ram_we   (ram_we),
    .i_ram_data (ram_q)
  );

  // Write-first synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    ram_q <= ram_we ? ram_wd : mem[ram_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] w,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [3:0] b0, input logic [3:0] b1);
    @(negedge clk);
    req      = r;
    we       = w;
    addr[0]  = a0;
    addr[1]  = a1;
    wdata[0] = d0;
    wdata[1] = d1;
    be[0]    = b0;
    be[1]    = b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) mem[i] = 32'h1000_0000 + i;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_gnt",    32'(gnt),      32'h0);
    check_output("rst_rvalid", 32'(rvalid),   32'h0);
    check_output("rst_rdata",  rdata,         32'h0);
    check_output("rst_ram_we", 32'(ram_we),   32'h0);
    check_output("rst_addr",   32'(ram_addr), 32'h0);
    check_output("rst_wdata",  ram_wd,        32'h0);

    // 1: two simultaneous reads
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2'b11, 2'b00, 4'd3, 4'd5, 0, 0, 4'h0, 4'h0);
    check_output("t1_gnt_a",  32'(gnt),      32'h1);
    check_output("t1_addr_a", 32'(ram_addr), 32'h3);
    check_output("t1_we_a",   32'(ram_we),   32'h0);
    apply_stimulus(2'b10, 2'b00, 4'd3, 4'd5, 0, 0, 4'h0, 4'h0);
    check_output("t1_gnt_b",    32'(gnt),      32'h2);
    check_output("t1_addr_b",   32'(ram_addr), 32'h5);
    check_output("t1_rvalid_b", 32'(rvalid),   32'h1);
    check_output("t1_rdata_b",  rdata,         32'h1000_0003);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("t1_gnt_c",    32'(gnt),    32'h0);
    check_output("t1_rvalid_c", 32'(rvalid), 32'h2);
    check_output("t1_rdata_c",  rdata,       32'h1000_0005);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("t1_rvalid_d", 32'(rvalid), 32'h0);
    check_output("t1_rdata_hold", rdata,     32'h1000_0005);

    // 2: full write then read of the same word on the next cycle
    apply_stimulus(2'b01, 2'b01, 4'd2, 0, 32'hDEAD_BEEF, 0, 4'hF, 4'h0);
    check_output("t2_gnt_w",  32'(gnt),      32'h1);
    check_output("t2_we_w",   32'(ram_we),   32'h1);
    check_output("t2_addr_w", 32'(ram_addr), 32'h2);
    check_output("t2_data_w", ram_wd,        32'hDEAD_BEEF);
    apply_stimulus(2'b10, 2'b00, 0, 4'd2, 0, 0, 4'h0, 4'h0);
    check_output("t2_gnt_r",    32'(gnt),    32'h2);
    check_output("t2_rvalid_w", 32'(rvalid), 32'h0);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("t2_rvalid", 32'(rvalid), 32'h2);
    check_output("t2_rdata",  rdata,       32'hDEAD_BEEF);

    // 3: byte-enable write merged over 0x11223344
    apply_stimulus(2'b01, 2'b01, 4'd4, 0, 32'h1122_3344, 0, 4'hF, 4'h0);
    check_output("t3_gnt_init", 32'(gnt), 32'h1);
    apply_stimulus(2'b01, 2'b01, 4'd4, 0, 32'hAABB_CCDD, 0, 4'b0101, 4'h0);
    check_output("t3_gnt_t",  32'(gnt),      32'h1);
    check_output("t3_we_t",   32'(ram_we),   32'h0);
    check_output("t3_addr_t", 32'(ram_addr), 32'h4);
    apply_stimulus(2'b10, 2'b00, 0, 4'd4, 0, 0, 4'h0, 4'h0);
    check_output("t3_gnt_t1",  32'(gnt),      32'h0);
    check_output("t3_we_t1",   32'(ram_we),   32'h1);
    check_output("t3_addr_t1", 32'(ram_addr), 32'h4);
    check_output("t3_data_t1", ram_wd,        32'h11BB_33DD);
    apply_stimulus(2'b10, 2'b00, 0, 4'd4, 0, 0, 4'h0, 4'h0);
    check_output("t3_gnt_t2", 32'(gnt), 32'h2);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("t3_rvalid", 32'(rvalid), 32'h2);
    check_output("t3_rdata",  rdata,       32'h11BB_33DD);

    // 4: both requesters saturating for 8 cycles
    g0 = 0;
    g1 = 0;
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(2'b11, 2'b00, 4'd0, 4'd1, 0, 0, 4'h0, 4'h0);
      check_output("t4_gnt", 32'(gnt), (c % 2 == 0) ? 32'h1 : 32'h2);
      if (gnt[0]) g0++;
      if (gnt[1]) g1++;
    end
    check_output("t4_cnt0", 32'(g0), 32'd4);
    check_output("t4_cnt1", 32'(g1), 32'd4);

    // be==0 write: granted but no RAM access
    apply_stimulus(2'b01, 2'b01, 4'd6, 0, 32'hFFFF_FFFF, 0, 4'h0, 4'h0);
    check_output("be0_gnt", 32'(gnt),    32'h1);
    check_output("be0_we",  32'(ram_we), 32'h0);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("be0_rvalid", 32'(rvalid), 32'h0);
    check_output("be0_we_n",   32'(ram_we), 32'h0);

    // 5: reset in the middle of an RMW aborts the write
    apply_stimulus(2'b01, 2'b01, 4'd6, 0, 32'hFFFF_FFFF, 0, 4'b0011, 4'h0);
    check_output("t5_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    check_output("t5_gnt_rst",    32'(gnt),      32'h0);
    check_output("t5_we_rst",     32'(ram_we),   32'h0);
    check_output("t5_addr_rst",   32'(ram_addr), 32'h0);
    check_output("t5_data_rst",   ram_wd,        32'h0);
    check_output("t5_rvalid_rst", 32'(rvalid),   32'h0);
    check_output("t5_rdata_rst",  rdata,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2'b11, 2'b00, 4'd6, 4'd6, 0, 0, 4'h0, 4'h0);
    check_output("t5_first_gnt", 32'(gnt), 32'h1);
    apply_stimulus(2'b10, 2'b00, 4'd6, 4'd6, 0, 0, 4'h0, 4'h0);
    check_output("t5_gnt_b",  32'(gnt), 32'h2);
    check_output("t5_rdata0", rdata,    32'h1000_0006);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("t5_rvalid1", 32'(rvalid), 32'h2);
    check_output("t5_rdata1",  rdata,       32'h1000_0006);

    // 6: req1 pulses during req0's RMW and drops before being granted
    apply_stimulus(2'b01, 2'b01, 4'd8, 4'd9, 32'h5A00_0000, 0, 4'b1000, 4'h0);
    check_output("t6_gnt_t", 32'(gnt), 32'h1);
    apply_stimulus(2'b10, 2'b00, 4'd8, 4'd9, 0, 0, 4'h0, 4'h0);
    check_output("t6_gnt_t1",  32'(gnt),    32'h0);
    check_output("t6_we_t1",   32'(ram_we), 32'h1);
    check_output("t6_data_t1", ram_wd,      32'h5A00_0008);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("t6_gnt_t2", 32'(gnt),    32'h0);
    check_output("t6_we_t2",  32'(ram_we), 32'h0);
    apply_stimulus(2'b01, 2'b00, 4'd8, 0, 0, 0, 4'h0, 4'h0);
    check_output("t6_rvalid_none", 32'(rvalid), 32'h0);
    check_output("t6_gnt_rd",      32'(gnt),    32'h1);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    check_output("t6_rvalid", 32'(rvalid), 32'h1);
    check_output("t6_rdata",  rdata,       32'h5A00_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
